scale_key_ctrl: RTL and testbench
=================================

# scale_key_ctrl

Parametrised key-driven output-resolution controller for the full-screen scaler. Debounces two push keys, adds auto-repeat on hold, and steps the target horizontal and vertical pixel counts with clamping. It fetches the matching scale factors from external scale ROMs and commits the new configuration atomically on a frame boundary, so the scaler never sees a torn H/V/scale set.

## Interface
- NUM_W, 11, width of TARGET_H_NUM / TARGET_V_NUM
- SCALE_W, 15, width of scale factors and ROM data
- INIT_H, 640, reset horizontal count
- INIT_V, 360, reset vertical count
- MIN_H / MAX_H, 16 / 1920, horizontal clamp limits
- MIN_V / MAX_V, 16 / 1080, vertical clamp limits
- STEP, 5, increment/decrement per event
- DEB_CYCLES, 2000000, clk cycles between key samples (debounce tick)
- REPEAT_DELAY, 25, ticks held before auto-repeat starts
- REPEAT_RATE, 5, ticks between auto-repeat events
- ROM_LAT, 1, ROM read latency in clk cycles (≥1)

Ports:
- clk  in  1  ddr_core 100 MHz, single clock
- rstn  in  1  asynchronous active-low reset
- key1  in  1  horizontal key, active-low (pressed = 0)
- key2  in  1  vertical key, active-low
- shift  in  1  0 = increase, 1 = decrease
- frame_start  in  1  one-cycle pulse at frame boundary
- x_rom_addr  out  NUM_W  x-scale ROM address
- x_rom_data  in  SCALE_W  x-scale ROM data
- y_rom_addr  out  NUM_W  y-scale ROM address
- y_rom_data  in  SCALE_W  y-scale ROM data
- x_scale  out  SCALE_W  committed x scale
- y_scale  out  SCALE_W  committed y scale
- TARGET_H_NUM  out  NUM_W  committed horizontal count
- TARGET_V_NUM  out  NUM_W  committed vertical count
- cfg_update  out  1  one-cycle pulse on commit

## Operation
- Tick counter 0..DEB_CYCLES-1; tick asserted when it wraps. On tick, both keys are sampled into key_scan; previous sample is held in key_scan_prev. Keys never change debounced state between ticks.
- Press event: key_scan_prev = 1, key_scan = 0 (falling edge), one cycle after the tick.
- Auto-repeat per key: while key_scan = 0, a hold counter counts ticks. When it reaches REPEAT_DELAY, one event fires, then one more every REPEAT_RATE ticks. Release (key_scan = 1) clears the hold counter.
- The two keys are independent. Simultaneous H and V events are both applied in the same cycle.
- Pending counts h_pend / v_pend. Arithmetic is done in NUM_W+1 bits:
  - increase: min(pend+STEP, MAX)
  - decrease: max(pend−STEP, MIN), with underflow caught before the compare
  - result at a limit is the limit; no wrap.
- An event that leaves pend unchanged (already clamped) does not dirty the state.
- ROM addresses are combinational: x_rom_addr = h_pend−1, y_rom_addr = v_pend−1.
- FSM:
  - IDLE: committed = pending. A dirtying event → LOOKUP.
  - LOOKUP: latency counter runs ROM_LAT cycles, then captures x_rom_data / y_rom_data into x_pend / y_pend → READY. A dirtying event restarts the counter at 0.
  - READY: frame_start → commit all four outputs simultaneously, pulse cfg_update, → IDLE. A dirtying event → LOOKUP, with no commit that frame.
  - frame_start in IDLE or LOOKUP is ignored.
- Event and frame_start in the same cycle while in READY: the event wins; no commit.
- Reset: h_pend = INIT_H, v_pend = INIT_V, TARGET_H_NUM = INIT_H, TARGET_V_NUM = INIT_V, x_scale = 0, y_scale = 0, cfg_update = 0, all counters = 0, key_scan / key_scan_prev = 2'b11. The FSM enters LOOKUP so the first frame_start after ROM_LAT commits valid scales. Reset mid-lookup discards pending values.

## Timing
- Event asserts 1 cycle after the tick that samples the press. pend updates on the following edge.
- Scales are captured ROM_LAT+1 cycles after the last pend change.
- cfg_update is high for exactly the cycle after the frame_start edge. Outputs change on that same edge and are held until the next commit.
- Auto-repeat period is REPEAT_RATE×DEB_CYCLES cycles; first repeat comes REPEAT_DELAY ticks after the press tick.
- All outputs are registered except the ROM addresses.

## Test plan
- Reset, ROM returns addr+100, frame_start after 5 cycles → cfg_update once; TARGET_H_NUM = 640, V = 360, x_scale = 739, y_scale = 459.
- DEB_CYCLES = 16: key1 pressed with shift = 0, frame_start → H = 645, V unchanged, x_scale = 744. Same with shift = 1 → back to 640.
- key1 and key2 pressed on the same tick, shift = 1 → single commit with H = 635, V = 355.
- Hold key1 with H starting at 1915 and shift = 0 → first event gives 1920; repeats never exceed 1920 and produce no further cfg_update. Hold from 20 with shift = 1 → 16, then stays at 16.
- REPEAT_DELAY = 3, REPEAT_RATE = 2: hold key1 for 10 ticks → events on ticks 0, 3, 5, 7, 9; H = 665 at the next commit.
- Key event coincident with frame_start while in READY → no cfg_update that frame. The next frame_start commits the newest value. Assert rstn during LOOKUP → outputs return to INIT and scales to 0.

Source files
------------

// File: rtl/scale_key_ctrl.sv
// Key-driven output-resolution controller: debounced keys with auto-repeat step clamped H/V
// counts, fetch matching scale factors from external ROMs and commit all four on a frame boundary.
module scale_key_ctrl #(
  parameter int unsigned NUM_W        = 11,
  parameter int unsigned SCALE_W      = 15,
  parameter int unsigned INIT_H       = 640,
  parameter int unsigned INIT_V       = 360,
  parameter int unsigned MIN_H        = 16,
  parameter int unsigned MAX_H        = 1920,
  parameter int unsigned MIN_V        = 16,
  parameter int unsigned MAX_V        = 1080,
  parameter int unsigned STEP         = 5,
  parameter int unsigned DEB_CYCLES   = 2000000,
  parameter int unsigned REPEAT_DELAY = 25,
  parameter int unsigned REPEAT_RATE  = 5,
  parameter int unsigned ROM_LAT      = 1
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               key1,
  input  logic               key2,
  input  logic               shift,
  input  logic               frame_start,
  output logic [NUM_W-1:0]   x_rom_addr,
  input  logic [SCALE_W-1:0] x_rom_data,
  output logic [NUM_W-1:0]   y_rom_addr,
  input  logic [SCALE_W-1:0] y_rom_data,
  output logic [SCALE_W-1:0] x_scale,
  output logic [SCALE_W-1:0] y_scale,
  output logic [NUM_W-1:0]   TARGET_H_NUM,
  output logic [NUM_W-1:0]   TARGET_V_NUM,
  output logic               cfg_update
);

  localparam int unsigned TickW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HoldMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned HoldW   = $clog2(HoldMax + 1);
  localparam int unsigned LatW    = (ROM_LAT > 0) ? $clog2(ROM_LAT + 1) : 1;
  localparam int unsigned ArW     = NUM_W + 1;

  typedef enum logic [1:0] {StIdle, StLookup, StReady} state_e;

  state_e                 state_q, state_d;
  logic [TickW-1:0]       tick_cnt_q, tick_cnt_d;
  logic                   tick, tick_q;
  logic [1:0]             key_meta_q, key_sync_q;
  logic [1:0]             key_scan_q, key_scan_prev_q;
  logic [1:0][HoldW-1:0]  hold_q, hold_d;
  logic [1:0]             rep_q, rep_d, fire, evt;
  logic [NUM_W-1:0]       h_pend_q, h_pend_d, v_pend_q, v_pend_d;
  logic [SCALE_W-1:0]     x_pend_q, x_pend_d, y_pend_q, y_pend_d;
  logic [LatW-1:0]        lat_q, lat_d;
  logic                   dirty, commit;
  logic [NUM_W-1:0]       tgt_h_q, tgt_v_q;
  logic [SCALE_W-1:0]     x_scale_q, y_scale_q;
  logic                   cfg_update_q;

  // Widened arithmetic so neither the add nor the subtract can wrap before the clamp compare.
  function automatic logic [NUM_W-1:0] step_val(input logic [NUM_W-1:0] cur, input logic dec,
                                                input logic [ArW-1:0] lo, input logic [ArW-1:0] hi);
    logic [ArW-1:0] wide;
    wide = {1'b0, cur};
    if (dec) begin
      step_val = (wide < lo + ArW'(STEP)) ? lo[NUM_W-1:0] : NUM_W'(wide - ArW'(STEP));
    end else begin
      step_val = (wide + ArW'(STEP) > hi) ? hi[NUM_W-1:0] : NUM_W'(wide + ArW'(STEP));
    end
  endfunction

  assign tick       = (tick_cnt_q == TickW'(DEB_CYCLES - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    hold_d = hold_q;
    rep_d  = rep_q;
    fire   = '0;
    evt    = '0;
    for (int i = 0; i < 2; i++) begin
      fire[i] = ~key_scan_q[i] & ~key_scan_prev_q[i] &
                (rep_q[i] ? (hold_q[i] == HoldW'(REPEAT_RATE))
                          : (hold_q[i] == HoldW'(REPEAT_DELAY)));
      evt[i]  = tick_q & ((key_scan_prev_q[i] & ~key_scan_q[i]) | fire[i]);
      if (tick_q) begin
        if (key_scan_q[i]) begin
          hold_d[i] = '0;
          rep_d[i]  = 1'b0;
        end else if (fire[i]) begin
          hold_d[i] = HoldW'(1);
          rep_d[i]  = 1'b1;
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    h_pend_d = evt[0] ? step_val(h_pend_q, shift, ArW'(MIN_H), ArW'(MAX_H)) : h_pend_q;
    v_pend_d = evt[1] ? step_val(v_pend_q, shift, ArW'(MIN_V), ArW'(MAX_V)) : v_pend_q;
    dirty    = (h_pend_d != h_pend_q) | (v_pend_d != v_pend_q);
  end

  assign x_rom_addr = h_pend_q - 1'b1;
  assign y_rom_addr = v_pend_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    x_pend_d = x_pend_q;
    y_pend_d = y_pend_q;
    commit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dirty) begin
          state_d = StLookup;
          lat_d   = '0;
        end
      end
      StLookup: begin
        if (dirty) begin
          lat_d = '0;
        end else if (lat_q == LatW'(ROM_LAT)) begin
          x_pend_d = x_rom_data;
          y_pend_d = y_rom_data;
          state_d  = StReady;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      StReady: begin
        // A fresh key event outranks a coincident frame_start: the set would be stale.
        if (dirty) begin
          state_d = StLookup;
          lat_d   = '0;
        end else if (frame_start) begin
          commit  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StLookup;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= StLookup;
      tick_cnt_q      <= '0;
      tick_q          <= 1'b0;
      key_meta_q      <= 2'b11;
      key_sync_q      <= 2'b11;
      key_scan_q      <= 2'b11;
      key_scan_prev_q <= 2'b11;
      hold_q          <= '0;
      rep_q           <= '0;
      h_pend_q        <= NUM_W'(INIT_H);
      v_pend_q        <= NUM_W'(INIT_V);
      x_pend_q        <= '0;
      y_pend_q        <= '0;
      lat_q           <= '0;
      tgt_h_q         <= NUM_W'(INIT_H);
      tgt_v_q         <= NUM_W'(INIT_V);
      x_scale_q       <= '0;
      y_scale_q       <= '0;
      cfg_update_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      tick_q     <= tick;
      key_meta_q <= {key2, key1};
      key_sync_q <= key_meta_q;
      if (tick) begin
        key_scan_q      <= key_sync_q;
        key_scan_prev_q <= key_scan_q;
      end
      hold_q       <= hold_d;
      rep_q        <= rep_d;
      h_pend_q     <= h_pend_d;
      v_pend_q     <= v_pend_d;
      x_pend_q     <= x_pend_d;
      y_pend_q     <= y_pend_d;
      lat_q        <= lat_d;
      cfg_update_q <= commit;
      if (commit) begin
        tgt_h_q   <= h_pend_q;
        tgt_v_q   <= v_pend_q;
        x_scale_q <= x_pend_q;
        y_scale_q <= y_pend_q;
      end
    end
  end

  assign TARGET_H_NUM = tgt_h_q;
  assign TARGET_V_NUM = tgt_v_q;
  assign x_scale      = x_scale_q;
  assign y_scale      = y_scale_q;
  assign cfg_update   = cfg_update_q;

endmodule

// File: tb/tb_scale_key_ctrl.sv
// Directed bench for scale_key_ctrl: short debounce tick, ROM model returning addr+100.
module tb_scale_key_ctrl;

  localparam int DEB = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        key1 = 1'b1;
  logic        key2 = 1'b1;
  logic        shift = 1'b0;
  logic        frame_start = 1'b0;
  logic [10:0] x_rom_addr, y_rom_addr, th, tv;
  logic [14:0] x_rom_data, y_rom_data, x_scale, y_scale;
  logic        cfg_update;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    x_rom_data <= 15'(x_rom_addr) + 15'd100;
    y_rom_data <= 15'(y_rom_addr) + 15'd100;
  end

  scale_key_ctrl #(
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (3),
    .REPEAT_RATE  (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .key1         (key1),
    .key2         (key2),
    .shift        (shift),
    .frame_start  (frame_start),
    .x_rom_addr   (x_rom_addr),
    .x_rom_data   (x_rom_data),
    .y_rom_addr   (y_rom_addr),
    .y_rom_data   (y_rom_data),
    .x_scale      (x_scale),
    .y_scale      (y_scale),
    .TARGET_H_NUM (th),
    .TARGET_V_NUM (tv),
    .cfg_update   (cfg_update)
  );

  task automatic frame(output int ups);
    ups = 0;
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    if (cfg_update) ups++;
    repeat (3) begin
      @(negedge clk);
      if (cfg_update) ups++;
    end
  endtask

  task automatic set_keys(input int sel, input logic v);
    if (sel != 2) key1 = v;
    if (sel != 1) key2 = v;
  endtask

  // Press keys, sync to the press event, hold for nticks debounce ticks in total, then release.
  task automatic press(input int sel, input int nticks);
    logic [10:0] a0;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    a0 = (sel == 2) ? y_rom_addr : x_rom_addr;
    set_keys(sel, 1'b0);
    for (int i = 0; i < 4 * DEB && !seen; i++) begin
      @(negedge clk);
      if (((sel == 2) ? y_rom_addr : x_rom_addr) != a0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL press_event: no pend change seen, wanted one within %0d cycles", 4 * DEB);
      errors++;
    end
    repeat ((nticks - 1) * DEB + 6) @(negedge clk);
    set_keys(sel, 1'b1);
    repeat (3 * DEB) @(negedge clk);
  endtask

  task automatic hold_cycles(input int sel, input int n);
    @(negedge clk) set_keys(sel, 1'b0);
    repeat (n) @(negedge clk);
    set_keys(sel, 1'b1);
    repeat (3 * DEB) @(negedge clk);
  endtask

  task automatic test_reset;
    int ups;
    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({th, tv, x_scale, y_scale, cfg_update} !== {11'd640, 11'd360, 15'd0, 15'd0, 1'b0}) begin
      $display("FAIL reset_values: H=%0d V=%0d xs=%0d ys=%0d cu=%b, want 640 360 0 0 0",
               th, tv, x_scale, y_scale, cfg_update);
      errors++;
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    frame(ups);
    checks++;
    if (ups !== 1) begin
      $display("FAIL reset_commit_pulses: got %0d, want 1", ups);
      errors++;
    end
    checks++;
    if ({th, tv, x_scale, y_scale} !== {11'd640, 11'd360, 15'd739, 15'd459}) begin
      $display("FAIL reset_commit: H=%0d V=%0d xs=%0d ys=%0d, want 640 360 739 459",
               th, tv, x_scale, y_scale);
      errors++;
    end
  endtask

  task automatic test_single_step;
    int ups;
    shift = 1'b0;
    press(1, 1);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, tv, x_scale} !== {11'd645, 11'd360, 15'd744}) begin
      $display("FAIL step_up: ups=%0d H=%0d V=%0d xs=%0d, want 1 645 360 744",
               ups, th, tv, x_scale);
      errors++;
    end
    shift = 1'b1;
    press(1, 1);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, tv, x_scale, y_scale} !== {11'd640, 11'd360, 15'd739, 15'd459}) begin
      $display("FAIL step_down: ups=%0d H=%0d V=%0d xs=%0d ys=%0d, want 1 640 360 739 459",
               ups, th, tv, x_scale, y_scale);
      errors++;
    end
  endtask

  task automatic test_repeat;
    int ups;
    shift = 1'b0;
    press(1, 10);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, x_scale} !== {11'd665, 15'd764}) begin
      $display("FAIL repeat_count: ups=%0d H=%0d xs=%0d, want 1 665 764", ups, th, x_scale);
      errors++;
    end
  endtask

  task automatic test_simultaneous;
    int ups;
    shift = 1'b1;
    press(3, 1);
    frame(ups);
    checks++;
    if (ups !== 1) begin
      $display("FAIL simul_pulses: got %0d, want 1", ups);
      errors++;
    end
    checks++;
    if ({th, tv, x_scale, y_scale} !== {11'd660, 11'd355, 15'd759, 15'd454}) begin
      $display("FAIL simul_values: H=%0d V=%0d xs=%0d ys=%0d, want 660 355 759 454",
               th, tv, x_scale, y_scale);
      errors++;
    end
  endtask

  task automatic test_coincident;
    int ups;
    logic [10:0] a0;
    bit seen;
    seen = 1'b0;
    ups = 0;
    shift = 1'b0;
    @(negedge clk);
    a0 = x_rom_addr;
    key1 = 1'b0;
    for (int i = 0; i < 4 * DEB && !seen; i++) begin
      @(negedge clk);
      if (x_rom_addr != a0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL coinc_press: no pend change seen, wanted one");
      errors++;
    end
    // First repeat event lands 3 ticks after the press event; align frame_start with it.
    repeat (3 * DEB - 2) @(negedge clk);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    key1 = 1'b1;
    if (cfg_update) ups++;
    repeat (3) begin
      @(negedge clk);
      if (cfg_update) ups++;
    end
    checks++;
    if (ups !== 0 || {th, tv, x_scale} !== {11'd660, 11'd355, 15'd759}) begin
      $display("FAIL coinc_no_commit: ups=%0d H=%0d V=%0d xs=%0d, want 0 660 355 759",
               ups, th, tv, x_scale);
      errors++;
    end
    repeat (3 * DEB) @(negedge clk);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, tv, x_scale} !== {11'd670, 11'd355, 15'd769}) begin
      $display("FAIL coinc_next_commit: ups=%0d H=%0d V=%0d xs=%0d, want 1 670 355 769",
               ups, th, tv, x_scale);
      errors++;
    end
  endtask

  task automatic test_clamp_max;
    int ups;
    shift = 1'b0;
    hold_cycles(1, 600 * DEB);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, x_scale} !== {11'd1920, 15'd2019}) begin
      $display("FAIL max_reach: ups=%0d H=%0d xs=%0d, want 1 1920 2019", ups, th, x_scale);
      errors++;
    end
    hold_cycles(1, 20);
    frame(ups);
    checks++;
    if (ups !== 0) begin
      $display("FAIL max_clamped_press: cfg_update pulses %0d, want 0", ups);
      errors++;
    end
    shift = 1'b1;
    press(1, 1);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, x_scale} !== {11'd1915, 15'd2014}) begin
      $display("FAIL max_back: ups=%0d H=%0d xs=%0d, want 1 1915 2014", ups, th, x_scale);
      errors++;
    end
    shift = 1'b0;
    press(1, 1);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, x_scale} !== {11'd1920, 15'd2019}) begin
      $display("FAIL max_from_1915: ups=%0d H=%0d xs=%0d, want 1 1920 2019", ups, th, x_scale);
      errors++;
    end
    hold_cycles(1, 10 * DEB);
    frame(ups);
    checks++;
    if (ups !== 0 || th !== 11'd1920) begin
      $display("FAIL max_repeat_hold: ups=%0d H=%0d, want 0 1920", ups, th);
      errors++;
    end
  endtask

  task automatic test_clamp_min;
    int ups;
    shift = 1'b1;
    hold_cycles(1, 800 * DEB);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, tv, x_scale} !== {11'd16, 11'd355, 15'd115}) begin
      $display("FAIL min_reach: ups=%0d H=%0d V=%0d xs=%0d, want 1 16 355 115",
               ups, th, tv, x_scale);
      errors++;
    end
    hold_cycles(1, 10 * DEB);
    frame(ups);
    checks++;
    if (ups !== 0 || th !== 11'd16) begin
      $display("FAIL min_repeat_hold: ups=%0d H=%0d, want 0 16", ups, th);
      errors++;
    end
  endtask

  task automatic test_reset_lookup;
    int ups;
    logic [10:0] a0;
    bit seen;
    seen = 1'b0;
    shift = 1'b0;
    @(negedge clk);
    a0 = y_rom_addr;
    key2 = 1'b0;
    for (int i = 0; i < 4 * DEB && !seen; i++) begin
      @(negedge clk);
      if (y_rom_addr != a0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      $display("FAIL rstlk_press: no V pend change seen, wanted one");
      errors++;
    end
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({th, tv, x_scale, y_scale, cfg_update} !== {11'd640, 11'd360, 15'd0, 15'd0, 1'b0}) begin
      $display("FAIL rstlk_values: H=%0d V=%0d xs=%0d ys=%0d cu=%b, want 640 360 0 0 0",
               th, tv, x_scale, y_scale, cfg_update);
      errors++;
    end
    key2 = 1'b1;
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    frame(ups);
    checks++;
    if (ups !== 1 || {th, tv, x_scale, y_scale} !== {11'd640, 11'd360, 15'd739, 15'd459}) begin
      $display("FAIL rstlk_commit: ups=%0d H=%0d V=%0d xs=%0d ys=%0d, want 1 640 360 739 459",
               ups, th, tv, x_scale, y_scale);
      errors++;
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_repeat();
    test_simultaneous();
    test_coincident();
    test_clamp_max();
    test_clamp_min();
    test_reset_lookup();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "watchdog");
  end

endmodule
